// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the 7-segment scan controller and its decoder.
// Combinational definitions only: no latency, no backpressure.
package seven_seg_pkg;

    typedef enum logic {
        S_SHOW  = 1'b0,
        S_BLANK = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int         BCD_W     = 4;

    // Phase counter must hold the longer of the two phase lengths minus one.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/seven_segment_scan_controller_if.sv
// Frame-load port of the scan controller: valid/ready handshake plus a BCD frame.
// Transfer occurs on a cycle with in_valid && in_ready; the master holds data until then.
interface seven_segment_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    import seven_seg_pkg::*;

    logic                          in_valid;
    logic                          in_ready;
    logic [BCD_W*NUM_DIGITS-1:0]   in_digits;

    modport master (output in_valid, output in_digits, input in_ready);
    modport slave  (input in_valid, input in_digits, output in_ready);

endinterface

// File: rtl/seven_segment_decoder.sv
// BCD to active-low segment pattern {g,f,e,d,c,b,a}; codes 10..15 give an all-off digit.
// Purely combinational, no backpressure.
module seven_segment_decoder
    import seven_seg_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg_n
);

    always_comb begin
        seg_n = SEG_BLANK;
        case (bcd)
            4'd0:    seg_n = 7'h40;
            4'd1:    seg_n = 7'h79;
            4'd2:    seg_n = 7'h24;
            4'd3:    seg_n = 7'h30;
            4'd4:    seg_n = 7'h19;
            4'd5:    seg_n = 7'h12;
            4'd6:    seg_n = 7'h02;
            4'd7:    seg_n = 7'h78;
            4'd8:    seg_n = 7'h00;
            4'd9:    seg_n = 7'h10;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed common-anode display scanner with blanking gaps; frames swap only at scan wrap.
// seg_n/an_n lag the FSM by 1 cycle; in_ready drops while a frame waits for the next wrap.
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 always shown).
module seven_segment_scan_controller
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    seven_segment_scan_controller_if.slave frm,
    output logic [6:0]                     seg_n,
    output logic [NUM_DIGITS-1:0]          an_n,
    output logic                           frame_done
);

    localparam int CNT_W = cnt_width(REFRESH_DIV, BLANK_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FW    = BCD_W * NUM_DIGITS;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             wrap;

    logic [FW-1:0]    active, shadow;
    logic             pending;
    logic             take;

    logic [BCD_W-1:0] cur_digit;
    logic [6:0]       dec_seg;
    logic             digit_blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BLANK;
            cnt   <= '0;
            idx   <= IDX_W'(NUM_DIGITS - 1);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        wrap      = 1'b0;
        case (state)
            S_SHOW: begin
                if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                    state_nxt = S_BLANK;
                    cnt_nxt   = '0;
                end
            end
            S_BLANK: begin
                if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_nxt = S_SHOW;
                    cnt_nxt   = '0;
                    if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                        idx_nxt = '0;
                        wrap    = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
        endcase
    end

    // Gated so a single-cycle blank phase cannot pulse while held in reset.
    assign frame_done   = wrap && !rst;
    assign frm.in_ready = !pending;
    assign take         = frm.in_valid && !pending;

    // A pending frame blocks capture, so commit and capture never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active  <= '1;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (wrap && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end else if (take) begin
            shadow  <= frm.in_digits;
            pending <= 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_mask;

    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [FW-1:0] f);
        logic [NUM_DIGITS-1:0] m;
        logic                  all0;
        m    = '0;
        all0 = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            all0 = all0 && (f[d*BCD_W +: BCD_W] == '0);
            m[d] = all0;
        end
        return m;
    endfunction

    // Mask follows the frame being committed so it is valid from the first lit digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lz_mask <= '0;
        end else if (wrap && pending) begin
            lz_mask <= lead_zero_mask(shadow);
        end
    end

    assign digit_blank = lz_mask[idx];
`else
    assign digit_blank = 1'b0;
`endif

    assign cur_digit = active[int'(idx)*BCD_W +: BCD_W];

    seven_segment_decoder u_dec (
        .bcd   (cur_digit),
        .seg_n (dec_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n <= SEG_BLANK;
            an_n  <= '1;
        end else if (state == S_SHOW) begin
            an_n  <= ~(NUM_DIGITS'(1) << idx);
            seg_n <= digit_blank ? SEG_BLANK : dec_seg;
        end else begin
            an_n  <= '1;
            seg_n <= SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Scoreboarded bench for seven_segment_scan_controller (4 digits, 4 lit + 2 blank cycles).
// Expected lit digits are queued per scan when frames are loaded; a monitor checks each digit.
module tb_seven_segment_scan_controller;
    import seven_seg_pkg::*;

    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int BC    = 2;
    localparam int FRAME = ND * (RD + BC);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    seg_n;
    logic [ND-1:0] an_n;
    logic          frame_done;

    seven_segment_scan_controller_if #(.NUM_DIGITS(ND)) frm ();

    seven_segment_scan_controller #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frm        (frm),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         scan;
        int         dig;
        logic [6:0] seg;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] bcd7(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic void push_range(input int scan, input logic [15:0] f, input int lo, input int hi);
        logic [ND-1:0] bl;
        exp_t          e;
`ifdef LEADING_ZERO_BLANK_EN
        logic          z;
`endif
        bl = '0;
`ifdef LEADING_ZERO_BLANK_EN
        z = 1'b1;
        for (int d = ND - 1; d >= 1; d--) begin
            z     = z && (f[d*4 +: 4] == 4'd0);
            bl[d] = z;
        end
`endif
        for (int d = lo; d <= hi; d++) begin
            e.scan = scan;
            e.dig  = d;
            e.seg  = bl[d] ? 7'h7F : bcd7(f[d*4 +: 4]);
            sb.push_back(e);
        end
    endfunction

    // Monitor state, updated on the falling edge
    int         sc, cyc, last_fd, gap, run, ep_scan;
    logic       lit, first_gap, stable;
    logic [3:0] ep_an;
    logic [6:0] ep_seg;

    task automatic end_episode();
        exp_t       e;
        logic [3:0] ea;
        chk("show_len", run, RD);
        chk("show_stable", {31'd0, stable}, 32'd1);
        while (sb.size() > 0 && sb[0].scan < ep_scan) begin
            e = sb.pop_front();
            chk($sformatf("missed_s%0d_d%0d", e.scan, e.dig), e.scan, ep_scan);
        end
        if (sb.size() > 0 && sb[0].scan == ep_scan) begin
            e  = sb.pop_front();
            ea = ~(4'b0001 << e.dig);
            chk($sformatf("anode_s%0d_d%0d", e.scan, e.dig), {28'd0, ep_an}, {28'd0, ea});
            chk($sformatf("seg_s%0d_d%0d", e.scan, e.dig), {25'd0, ep_seg}, {25'd0, e.seg});
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sc        = 0;
            cyc       = 0;
            last_fd   = -1;
            gap       = 0;
            run       = 0;
            lit       = 1'b0;
            first_gap = 1'b1;
            stable    = 1'b1;
        end else begin
            cyc++;
            if (frame_done) begin
                if (last_fd >= 0) chk("fd_period", cyc - last_fd, FRAME);
                last_fd = cyc;
                sc++;
            end
            if (an_n != 4'hF) begin
                if (!lit) begin
                    if (!first_gap) chk("blank_gap", gap, BC);
                    first_gap = 1'b0;
                    lit       = 1'b1;
                    ep_an     = an_n;
                    ep_seg    = seg_n;
                    ep_scan   = sc;
                    run       = 1;
                    stable    = 1'b1;
                end else begin
                    run++;
                    if (an_n != ep_an || seg_n != ep_seg) stable = 1'b0;
                end
            end else begin
                if (seg_n != 7'h7F) chk("seg_off_when_blank", {25'd0, seg_n}, 32'h7F);
                if (lit) begin
                    end_episode();
                    lit = 1'b0;
                    gap = 1;
                end else begin
                    gap++;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_sc(input int target);
        int n;
        n = 0;
        while (sc < target && n < 8 * FRAME) begin
            step();
            n++;
        end
        if (sc < target) chk("scan_timeout", sc, target);
    endtask

    task automatic send(input logic [15:0] f);
        int   n;
        logic prev_fd;
        int   acc;
        n              = 0;
        frm.in_valid   = 1'b1;
        frm.in_digits  = f;
        prev_fd        = frame_done;
        while (!frm.in_ready && n < 4 * FRAME) begin
            prev_fd = frame_done;
            step();
            n++;
        end
        if (!frm.in_ready) begin
            chk("ready_timeout", {31'd0, frm.in_ready}, 32'd1);
        end else begin
            if (n > 0) chk("ready_after_wrap", {31'd0, prev_fd}, 32'd1);
            acc = sc;
            push_range(acc + 1, f, 0, ND - 1);
        end
        step();
        frm.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        frm.in_valid  = 1'b0;
        frm.in_digits = '0;
        rst           = 1'b1;
        repeat (3) step();
        chk("rst_an_n", {28'd0, an_n}, 32'hF);
        chk("rst_seg_n", {25'd0, seg_n}, 32'h7F);
        chk("rst_in_ready", {31'd0, frm.in_ready}, 32'd1);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        // Idle scans display the all-F reset frame as blank digits
        push_range(1, 16'hFFFF, 0, ND - 1);
        push_range(2, 16'hFFFF, 0, ND - 1);
        wait_sc(2);

        // Load, then offer a second frame while the first is pending
        send(16'h1234);
        chk("busy_ready", {31'd0, frm.in_ready}, 32'd0);
        send(16'h5678);
        wait_sc(sc + 2);

        // Mid-scan load during digit 2: rest of this scan keeps the old frame
        n = 0;
        while (!(lit && ep_an == 4'b1011) && n < 2 * FRAME) begin
            step();
            n++;
        end
        chk("found_digit2", {28'd0, ep_an}, 32'hB);
        k = sc;
        push_range(k, 16'h5678, 2, 3);
        send(16'h9080);
        wait_sc(sc + 2);

        // Invalid BCD code and leading zeros
        send(16'h00A7);
        wait_sc(sc + 2);
        send(16'h0000);
        wait_sc(sc + 2);

        // Reset while a frame is pending and a digit is lit
        n = 0;
        while (!frame_done && n < 2 * FRAME) begin
            step();
            n++;
        end
        send(16'h4321);
        repeat (3) step();
        chk("t6_lit", {31'd0, (an_n != 4'hF)}, 32'd1);
        chk("t6_pending", {31'd0, frm.in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("t6_rst_an_n", {28'd0, an_n}, 32'hF);
        chk("t6_rst_seg_n", {25'd0, seg_n}, 32'h7F);
        chk("t6_rst_ready", {31'd0, frm.in_ready}, 32'd1);
        sb.delete();
        repeat (2) step();
        rst = 1'b0;
        push_range(1, 16'hFFFF, 0, ND - 1);
        push_range(2, 16'hFFFF, 0, ND - 1);
        wait_sc(3);
        repeat (RD + BC) step();

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
